// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle control FSM sequencing the RV64I-subset datapath

module multicycle_control_unit #(
   parameter int WORDSIZE         = 64,
   parameter int INSTRUCTION_SIZE = 32,
   parameter int MEM_TIMEOUT      = 16
) (
   input  logic                        cpu_clk,
   input  logic                        cpu_rst_n,
   input  logic                        cpu_halt,
   input  logic [INSTRUCTION_SIZE-1:0] ctl_instr,
   input  logic                        alu_zero,
   input  logic                        dm_ready,
   output logic                        ir_load,
   output logic                        pc_en,
   output logic                        rf_we,
   output logic                        dm_re,
   output logic                        dm_we,
   output logic                        mux_0_sel,
   output logic [1:0]                  mux_1_sel,
   output logic                        mux_2_sel,
   output logic [3:0]                  alu_op,
   output logic                        trap,
   output logic                        trap_cause,
   output logic [WORDSIZE-1:0]         retired,
   output logic [2:0]                  state
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd7
   } state_t;

   state_t                      state_q;
   logic [INSTRUCTION_SIZE-1:0] ir;
   logic [WCW-1:0]              wait_cnt;
   logic                        trap_cause_q;
   logic [WORDSIZE-1:0]         retired_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       is_r, is_i, is_ld, is_sd, is_br, is_jal, legal;
   logic       br_taken, mem_limit;
   logic [3:0] alu_fn, dec_alu;
   logic       unused_ir_bits;

   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign funct7_b5 = ir[30];

   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_I);
   assign is_ld  = (opcode == OP_LD);
   assign is_sd  = (opcode == OP_SD);
   assign is_br  = (opcode == OP_BR) && (funct3[2:1] == 2'b00);
   assign is_jal = (opcode == OP_JAL);
   assign legal  = is_r | is_i | is_ld | is_sd | is_br | is_jal;

   assign unused_ir_bits = ^{ir[INSTRUCTION_SIZE-1:31], ir[29:15], ir[11:7]};

   // funct3[0] selects BNE over BEQ
   assign br_taken  = is_br && (funct3[0] ? !alu_zero : alu_zero);
   assign mem_limit = (wait_cnt == WCW'(MEM_TIMEOUT - 1));

   always_comb begin
      alu_fn = ALU_ADD;
      case (funct3)
         3'b000:  alu_fn = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_fn = ALU_SLL;
         3'b010:  alu_fn = ALU_SLT;
         3'b011:  alu_fn = ALU_SLTU;
         3'b100:  alu_fn = ALU_XOR;
         3'b101:  alu_fn = funct7_b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_fn = ALU_OR;
         default: alu_fn = ALU_AND;
      endcase
   end

   always_comb begin
      if (is_r || is_i)
         dec_alu = alu_fn;
      else if (is_br)
         dec_alu = ALU_SUB;
      else
         dec_alu = ALU_ADD;
   end

   // ALU controls are held through MEMORY/WRITEBACK since there is no ALU output register
   always_comb begin
      ir_load   = 1'b0;
      pc_en     = 1'b0;
      rf_we     = 1'b0;
      dm_re     = 1'b0;
      dm_we     = 1'b0;
      mux_0_sel = 1'b0;
      mux_1_sel = 2'd0;
      mux_2_sel = 1'b0;
      alu_op    = ALU_ADD;
      if (cpu_rst_n) begin
         case (state_q)
            S_FETCH: begin
               ir_load = !cpu_halt;
            end
            S_EXECUTE: begin
               alu_op    = dec_alu;
               mux_0_sel = is_i | is_ld | is_sd;
               if (is_br) begin
                  pc_en     = 1'b1;
                  mux_2_sel = br_taken;
               end
            end
            S_MEMORY: begin
               alu_op    = dec_alu;
               mux_0_sel = 1'b1;
               dm_re     = is_ld;
               dm_we     = is_sd;
               pc_en     = is_sd & dm_ready;
            end
            S_WRITEBACK: begin
               alu_op    = dec_alu;
               mux_0_sel = is_i | is_ld;
               rf_we     = 1'b1;
               pc_en     = 1'b1;
               mux_1_sel = is_jal ? 2'd2 : (is_ld ? 2'd1 : 2'd0);
               mux_2_sel = is_jal;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst_n) begin
         state_q      <= S_FETCH;
         ir           <= '0;
         wait_cnt     <= '0;
         trap_cause_q <= 1'b0;
         retired_q    <= '0;
      end else begin
         if (pc_en)
            retired_q <= retired_q + WORDSIZE'(1);
         case (state_q)
            S_FETCH: begin
               if (!cpu_halt) begin
                  ir      <= ctl_instr;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!legal) begin
                  state_q      <= S_TRAP;
                  trap_cause_q <= 1'b0;
               end else begin
                  state_q <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               if (is_br) begin
                  state_q <= S_FETCH;
               end else if (is_ld || is_sd) begin
                  state_q  <= S_MEMORY;
                  wait_cnt <= '0;
               end else begin
                  state_q <= S_WRITEBACK;
               end
            end
            S_MEMORY: begin
               // a ready arriving on the limit cycle completes the access
               if (dm_ready) begin
                  state_q <= is_sd ? S_FETCH : S_WRITEBACK;
               end else if (mem_limit) begin
                  state_q      <= S_TRAP;
                  trap_cause_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            S_WRITEBACK: begin
               state_q <= S_FETCH;
            end
            S_TRAP: begin
               state_q <= S_TRAP;
            end
            default: begin
               state_q      <= S_TRAP;
               trap_cause_q <= 1'b0;
            end
         endcase
      end
   end

   assign trap       = (state_q == S_TRAP);
   assign trap_cause = trap_cause_q;
   assign retired    = retired_q;
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit

module tb_multicycle_control_unit;

   localparam int T = 16;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst_n = 1'b0;
   logic        cpu_halt = 1'b0;
   logic [31:0] ctl_instr = '0;
   logic        alu_zero = 1'b0;
   logic        dm_ready = 1'b0;
   logic        ir_load, pc_en, rf_we, dm_re, dm_we;
   logic        mux_0_sel, mux_2_sel;
   logic [1:0]  mux_1_sel;
   logic [3:0]  alu_op;
   logic        trap, trap_cause;
   logic [63:0] retired;
   logic [2:0]  state;

   multicycle_control_unit #(.WORDSIZE(64), .INSTRUCTION_SIZE(32), .MEM_TIMEOUT(T)) dut (
      .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .cpu_halt(cpu_halt), .ctl_instr(ctl_instr),
      .alu_zero(alu_zero), .dm_ready(dm_ready), .ir_load(ir_load), .pc_en(pc_en),
      .rf_we(rf_we), .dm_re(dm_re), .dm_we(dm_we), .mux_0_sel(mux_0_sel),
      .mux_1_sel(mux_1_sel), .mux_2_sel(mux_2_sel), .alu_op(alu_op), .trap(trap),
      .trap_cause(trap_cause), .retired(retired), .state(state)
   );

   always #5 cpu_clk = ~cpu_clk;

   localparam logic [4:0] IR = 5'b10000, PC = 5'b01000, RF = 5'b00100, RE = 5'b00010, WE = 5'b00001;

   typedef struct {
      logic [2:0] st;
      logic [4:0] strb;
      logic       rdy;
      logic       zro;
      bit         c_m0;
      logic       m0;
      bit         c_m1;
      logic [1:0] m1;
      bit         c_m2;
      logic       m2;
      bit         c_alu;
      logic [3:0] alu;
      logic       trp;
      logic       cause;
   } step_t;

   step_t       q[$];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] ret_model = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic step_t blank(input logic [2:0] st);
      step_t s;
      s.st = st; s.strb = '0;
      s.rdy = 1'($urandom_range(0, 1));
      s.zro = 1'($urandom_range(0, 1));
      s.c_m0 = 0; s.m0 = 0; s.c_m1 = 0; s.m1 = 0; s.c_m2 = 0; s.m2 = 0;
      s.c_alu = 0; s.alu = 0; s.trp = 0; s.cause = 0;
      return s;
   endfunction

   // operation named by funct3 for the ALU classes (ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND)
   function automatic logic [3:0] ref_alu(input logic [31:0] ins);
      logic [3:0] base_op [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
      logic [2:0] f3 = ins[14:12];
      logic       rtype = (ins[6:0] == 7'b0110011);
      logic       itype = (ins[6:0] == 7'b0010011);
      if (ins[6:0] == 7'b1100011) return 4'd1;
      if (!(rtype || itype)) return 4'd0;
      if (f3 == 3'd0 && rtype && ins[30]) return 4'd1;
      if (f3 == 3'd5 && ins[30]) return 4'd7;
      return base_op[f3];
   endfunction

   // expected cycle-by-cycle trace from the class latency rules; w = cycles ready stays low
   task automatic build(input logic [31:0] ins, input int w, input logic zero);
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      logic r = (op == 7'b0110011), i = (op == 7'b0010011), ld = (op == 7'b0000011);
      logic sd = (op == 7'b0100011), jal = (op == 7'b1101111);
      logic br = (op == 7'b1100011) && (f3 == 3'd0 || f3 == 3'd1);
      step_t s;
      int n;
      q.delete();
      ctl_instr = ins;
      s = blank(3'd0); s.strb = IR; q.push_back(s);
      s = blank(3'd1); q.push_back(s);
      if (!(r || i || ld || sd || br || jal)) begin
         repeat (10) begin s = blank(3'd7); s.trp = 1; s.cause = 0; q.push_back(s); end
         return;
      end
      s = blank(3'd2); s.c_alu = 1; s.alu = ref_alu(ins);
      if (r) begin s.c_m0 = 1; s.m0 = 0; end
      if (i) begin s.c_m0 = 1; s.m0 = 1; end
      if (br) begin
         s.zro = zero; s.strb = PC; s.c_m2 = 1;
         s.m2 = f3[0] ? !zero : zero;
         q.push_back(s);
         return;
      end
      q.push_back(s);
      if (ld || sd) begin
         n = (w < T) ? w + 1 : T;
         for (int j = 0; j < n; j++) begin
            s = blank(3'd3); s.c_m0 = 1; s.m0 = 1;
            s.rdy = (j == w);
            s.strb = ld ? RE : WE;
            if (sd && j == w) s.strb = s.strb | PC;
            q.push_back(s);
         end
         if (w >= T) begin
            repeat (10) begin s = blank(3'd7); s.trp = 1; s.cause = 1; q.push_back(s); end
            return;
         end
         if (sd) return;
      end
      s = blank(3'd4); s.strb = RF | PC; s.c_m1 = 1; s.c_m2 = 1;
      s.m1 = jal ? 2'd2 : (ld ? 2'd1 : 2'd0);
      s.m2 = jal;
      q.push_back(s);
   endtask

   task automatic run_trace(input int upto);
      for (int k = 0; k < upto; k++) begin
         @(negedge cpu_clk);
         cpu_halt = 1'b0;
         dm_ready = q[k].rdy;
         alu_zero = q[k].zro;
         #1;
         chk($sformatf("state[%0d]", k), 64'(state), 64'(q[k].st));
         chk($sformatf("strobes[%0d]", k), 64'({ir_load, pc_en, rf_we, dm_re, dm_we}), 64'(q[k].strb));
         chk($sformatf("retired[%0d]", k), retired, ret_model);
         chk($sformatf("trap[%0d]", k), 64'(trap), 64'(q[k].trp));
         if (q[k].trp) chk($sformatf("trap_cause[%0d]", k), 64'(trap_cause), 64'(q[k].cause));
         if (q[k].c_m0) chk($sformatf("mux_0_sel[%0d]", k), 64'(mux_0_sel), 64'(q[k].m0));
         if (q[k].c_m1) chk($sformatf("mux_1_sel[%0d]", k), 64'(mux_1_sel), 64'(q[k].m1));
         if (q[k].c_m2) chk($sformatf("mux_2_sel[%0d]", k), 64'(mux_2_sel), 64'(q[k].m2));
         if (q[k].c_alu) chk($sformatf("alu_op[%0d]", k), 64'(alu_op), 64'(q[k].alu));
         if (q[k].strb[3]) ret_model = ret_model + 64'd1;
      end
   endtask

   task automatic do_step(input logic [31:0] ins, input int w, input logic zero);
      build(ins, w, zero);
      run_trace(q.size());
   endtask

   task automatic do_reset();
      @(negedge cpu_clk);
      cpu_rst_n = 1'b0;
      cpu_halt  = 1'b0;
      dm_ready  = 1'b1;
      #1;
      chk("rst_strobes", 64'({ir_load, pc_en, rf_we, dm_re, dm_we}), 64'd0);
      chk("rst_muxes", 64'({mux_0_sel, mux_1_sel, mux_2_sel, alu_op}), 64'd0);
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;
      cpu_halt  = 1'b1;
      #1;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_trap", 64'({trap, trap_cause}), 64'd0);
      chk("rst_retired", retired, 64'd0);
      ret_model = '0;
   endtask

   function automatic logic [31:0] rand_ins(input int cls);
      logic [31:0] x = $urandom;
      case (cls)
         0:       x[6:0] = 7'b0110011;
         1:       x[6:0] = 7'b0010011;
         2:       x[6:0] = 7'b0000011;
         3:       x[6:0] = 7'b0100011;
         4:       begin x[6:0] = 7'b1100011; x[14:13] = 2'b00; end
         default: x[6:0] = 7'b1101111;
      endcase
      return x;
   endfunction

   initial begin
      do_reset();

      do_step(32'h002081B3, 0, 1'b0);   // add x3,x1,x2
      do_step(32'h402081B3, 0, 1'b0);   // sub x3,x1,x2
      do_step(32'h0000B183, 2, 1'b0);   // ld x3,0(x1), ready after 2 low cycles
      do_step(32'h0020B023, 0, 1'b0);   // sd x2,0(x1), ready immediately
      do_step(32'h00208463, 0, 1'b1);   // beq taken
      do_step(32'h00209463, 0, 1'b1);   // bne not taken
      do_step(32'h00209463, 0, 1'b0);   // bne taken
      do_step(32'h008000EF, 0, 1'b0);   // jal
      do_step(32'h4010D193, 0, 1'b0);   // srai
      do_step(32'h4000C193, 0, 1'b0);   // xori with funct7 bit set

      for (int k = 0; k < 5; k++) begin
         @(negedge cpu_clk);
         cpu_halt = 1'b1;
         #1;
         chk("halt_ir_load", 64'(ir_load), 64'd0);
         chk("halt_state", 64'(state), 64'd0);
         chk("halt_retired", retired, ret_model);
      end

      do_step(32'h0000B183, T - 1, 1'b0); // ready on the last allowed cycle
      do_step(32'h0020B023, T - 1, 1'b0);

      for (int n = 0; n < 40; n++)
         do_step(rand_ins($urandom_range(0, 5)), $urandom_range(0, T - 1), 1'($urandom_range(0, 1)));

      build(32'h0000B183, 100, 1'b0);
      run_trace(4);
      @(negedge cpu_clk);
      cpu_rst_n = 1'b0;
      dm_ready  = 1'b0;
      #1;
      chk("midrst_state", 64'(state), 64'd3);
      chk("midrst_dm_re", 64'(dm_re), 64'd0);
      chk("midrst_strobes", 64'({ir_load, pc_en, rf_we, dm_re, dm_we}), 64'd0);
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;
      cpu_halt  = 1'b1;
      #1;
      chk("midrst_fetch", 64'(state), 64'd0);
      chk("midrst_retired", retired, 64'd0);
      ret_model = '0;

      do_step(32'h0000007F, 0, 1'b0);   // illegal opcode
      do_reset();
      do_step(32'h0020A063, 0, 1'b0);   // branch with funct3 010
      do_reset();
      do_step(32'h0000B183, 100, 1'b0); // load that never completes
      do_reset();
      do_step(32'h002081B3, 0, 1'b0);
      do_step(32'h008000EF, 0, 1'b0);

      @(negedge cpu_clk);
      cpu_halt = 1'b1;
      #1;
      chk("final_retired", retired, ret_model);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multicycle control FSM that sequences the CPU datapath from one clock. It drives the instruction register load, PC update, register-file write, data-memory strobes, the three datapath mux selects and the ALU operation. It replaces the separate PC clock with a one-cycle pc_en per retired instruction. Covers an RV64I subset: R-ALU, I-ALU, LD, SD, BEQ/BNE, JAL. Includes a data-memory ready handshake with timeout and a trap state.

Parameters:
WORDSIZE, 64, width of the retired-instruction counter
INSTRUCTION_SIZE, 32, instruction width
MEM_TIMEOUT, 16, maximum MEMORY-state wait cycles before a trap (at least 1)

Ports:
cpu_clk  in  1  clock; all state changes on the rising edge
cpu_rst_n  in  1  reset, synchronous and active-low
cpu_halt  in  1  when 1, the FSM stays in FETCH and issues no ir_load
ctl_instr  in  INSTRUCTION_SIZE  instruction-memory output; captured internally when ir_load=1
alu_zero  in  1  ALU zero flag, valid in EXECUTE
dm_ready  in  1  data-memory access completes this cycle
ir_load  out  1  latch the instruction
pc_en  out  1  PC update strobe
rf_we  out  1  register-file write enable
dm_re  out  1  data-memory read strobe
dm_we  out  1  data-memory write strobe
mux_0_sel  out  1  ALU B source: 0 = rf_data_b, 1 = immediate
mux_1_sel  out  2  writeback source: 0 = ALU, 1 = dm_data_out, 2 = PC+4
mux_2_sel  out  1  next PC: 0 = PC+4, 1 = branch/jump target
alu_op  out  4  operation code
trap  out  1  sticky; 1 = illegal instruction or memory timeout
trap_cause  out  1  0 = illegal, 1 = timeout; valid when trap=1
retired  out  WORDSIZE  count of retired instructions
state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=7

Behaviour:
- Reset (cpu_rst_n=0 at an edge): state=FETCH, retired=0, trap=0, trap_cause=0, internal instruction register=0, wait counter=0.
- While cpu_rst_n=0, all strobes (ir_load, pc_en, rf_we, dm_re, dm_we) are forced 0. Mux selects and alu_op are 0.
- Outputs are decoded from the state and the captured instruction. pc_en and the MEMORY exit also depend on dm_ready and alu_zero in the same cycle.
- FETCH: if cpu_halt=0, ir_load=1 and go to DECODE. If cpu_halt=1, stay in FETCH with all strobes 0.
- DECODE: if the opcode is not one of 0110011, 0010011, 0000011, 0100011, 1100011 (funct3 000 or 001), 1101111, go to TRAP with trap_cause=0. Otherwise go to EXECUTE.
- EXECUTE, ALU:
  - R-type: alu_op is taken from funct3 and funct7[5].
  - I-ALU: same as R-type, except funct7[5] is used only for SRAI. mux_0_sel=1.
  - LD/SD/JAL: alu_op=ADD.
  - Branch: alu_op=SUB.
  - Encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- EXECUTE, next state:
  - Branch: pc_en=1. mux_2_sel=1 if taken (BEQ and alu_zero=1, or BNE and alu_zero=0), else 0. Retire and go to FETCH.
  - LD/SD: go to MEMORY and clear the wait counter.
  - R/I/JAL: go to WRITEBACK.
- MEMORY: hold dm_re (LD) or dm_we (SD) at 1 and mux_0_sel=1.
  - On dm_ready=1: SD asserts pc_en, retires and goes to FETCH; LD goes to WRITEBACK.
  - Otherwise increment the wait counter. When it reaches MEM_TIMEOUT with dm_ready still 0, go to TRAP with trap_cause=1.
  - dm_ready in the same cycle as the limit wins, so no trap.
- WRITEBACK: rf_we=1 and pc_en=1. Retire and go to FETCH.
  - mux_1_sel = 0 for R/I, 1 for LD, 2 for JAL.
  - mux_2_sel = 1 for JAL, else 0.
- Retire: retired increments by 1 on the same edge as pc_en=1 and wraps modulo 2^WORDSIZE. pc_en is high exactly one cycle per retired instruction.
- Latency (cycles, FETCH to next FETCH): branch 3, R/I/JAL 4, SD 4+w, LD 5+w, where w = cycles dm_ready stays low.
- TRAP: absorbing state, all strobes 0, trap=1. Exit only by reset.
- Reset mid-operation: abandons any access. Strobes drop in the cycle reset is low, and the FSM restarts at FETCH.
- cpu_halt is sampled only in FETCH. An in-flight instruction always completes.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) -> states 0,1,2,4. rf_we=1 and pc_en=1 in cycle 4 with mux_1_sel=0, alu_op=0. retired=1.
- LD with dm_ready low for 2 cycles -> dm_re high 3 cycles. WRITEBACK with mux_1_sel=1. Total 7 cycles. SD with dm_ready immediate -> dm_we 1 cycle, pc_en in MEMORY, 4 cycles.
- BEQ with alu_zero=1 -> pc_en and mux_2_sel=1 in EXECUTE, 3 cycles. BNE with alu_zero=1 -> mux_2_sel=0. JAL -> mux_1_sel=2, mux_2_sel=1, rf_we=1.
- Opcode 0x0000007F -> TRAP after DECODE, trap=1, trap_cause=0, no strobes for 10 cycles. Then cpu_rst_n=0 for 1 edge -> state=0, trap=0, retired=0.
- LD with dm_ready never asserted, MEM_TIMEOUT=16 -> TRAP with trap_cause=1 after 16 MEMORY cycles. Repeat with dm_ready on the 16th cycle -> no trap.
- cpu_halt=1 in FETCH for 5 cycles -> no ir_load and retired unchanged. Reset asserted during MEMORY -> dm_re=0 in that cycle, FETCH next.
